// File: rtl/memory_dma_wide.sv
// Byte-stream DMA between rx/tx byte FIFOs and a wide memory port.
// Big-endian lane mapping, arbitrary alignment, partial-word masks.
module memory_dma_wide #(
  parameter int MEM_BYTES  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   direction,
  input  logic [ADDR_WIDTH-1:0]  starting_address,
  input  logic [LEN_WIDTH-1:0]   transfer_length,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_WIDTH-1:0]   remaining,
  output logic                   request,
  input  logic                   ack,
  output logic                   write,
  output logic [MEM_BYTES-1:0]   wmask,
  output logic [ADDR_WIDTH-1:0]  address,
  input  logic [8*MEM_BYTES-1:0] rdata,
  output logic [8*MEM_BYTES-1:0] wdata,
  input  logic                   rx_empty,
  input  logic                   rx_almost_empty,
  output logic                   rx_read,
  input  logic [7:0]             rx_rdata,
  input  logic                   tx_full,
  input  logic                   tx_almost_full,
  output logic                   tx_write,
  output logic [7:0]             tx_wdata
);

  localparam int OB = $clog2(MEM_BYTES);
  localparam int CW = OB + 1;
  localparam int DW = 8 * MEM_BYTES;
  localparam logic [OB-1:0] LAST = OB'(MEM_BYTES - 1);
  localparam logic [CW-1:0] WORD = CW'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    TRANSFER,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  logic [DW-1:0] rbuf;
  logic [CW-1:0] gathered;
  logic          pend;

  logic [OB-1:0] off;
  logic [CW-1:0] lanes_left;
  logic [CW-1:0] need;
  logic [CW:0]   issued;
  logic [CW-1:0] gathered_nx;
  logic          pop_ok;
  logic          push_ok;
  logic          rd_last;
  logic [OB-1:0] cap_idx;
  logic [OB-1:0] tx_idx;
  logic [7:0]    tx_byte;

  logic do_start;
  logic do_stop;
  logic pop;
  logic push;
  logic cap_en;
  logic w_close;
  logic w_ack;
  logic r_ack;
  logic req_set;

  // Bytes the current word still needs: up to the lane end or the tail.
  assign off        = address[OB-1:0];
  assign lanes_left = WORD - CW'(off);
  assign need       = (remaining < LEN_WIDTH'(lanes_left))
                    ? CW'(remaining) : lanes_left;

  // Pops in flight count against the word so none overshoot it.
  assign issued      = {1'b0, gathered}
                     + (CW+1)'(rx_read)
                     + (CW+1)'(pend);
  assign gathered_nx = gathered + CW'(pend);

  assign pop_ok  = (issued < {1'b0, need})
                 && !rx_empty
                 && !(rx_read && rx_almost_empty);
  assign push_ok = !tx_full
                 && !(tx_write && tx_almost_full);
  assign rd_last = (off == LAST)
                 || (remaining == LEN_WIDTH'(1));

  assign cap_idx = LAST - (off + gathered[OB-1:0]);
  assign tx_idx  = LAST - off;
  assign cap_en  = (state == FETCH) && write
                 && pend && !stop;

  // Select the outgoing byte from the read word buffer.
  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (tx_idx == OB'(i)) tx_byte = rbuf[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_stop    = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    w_close    = 1'b0;
    w_ack      = 1'b0;
    r_ack      = 1'b0;
    req_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          do_start   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (stop) begin
          do_stop    = 1'b1;
          state_next = IDLE;
        end else if (remaining == '0) begin
          state_next = FINISH;
        end else if (write) begin
          pop = pop_ok;
          if (gathered_nx == need) begin
            w_close    = 1'b1;
            state_next = TRANSFER;
          end
        end else if (request && ack) begin
          r_ack      = 1'b1;
          state_next = TRANSFER;
        end else if (!request) begin
          req_set = 1'b1;
        end
      end
      TRANSFER: begin
        if (stop) begin
          do_stop    = 1'b1;
          state_next = IDLE;
        end else if (write) begin
          if (request && ack) begin
            w_ack      = 1'b1;
            state_next = FETCH;
          end
        end else if (push_ok) begin
          push = 1'b1;
          if (rd_last) state_next = FETCH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counters, word assembly, memory and FIFO strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      request   <= 1'b0;
      write     <= 1'b0;
      wmask     <= '0;
      address   <= '0;
      wdata     <= '0;
      rx_read   <= 1'b0;
      tx_write  <= 1'b0;
      tx_wdata  <= '0;
      rbuf      <= '0;
      gathered  <= '0;
      pend      <= 1'b0;
    end else begin
      done     <= (state_next == FINISH);
      rx_read  <= pop;
      pend     <= rx_read;
      tx_write <= push;

      if (cap_en) begin
        for (int i = 0; i < MEM_BYTES; i++) begin
          if (cap_idx == OB'(i)) begin
            wdata[8*i +: 8] <= rx_rdata;
            wmask[i]        <= 1'b1;
          end
        end
        gathered <= gathered_nx;
      end

      if (w_close) request <= 1'b1;
      if (req_set) request <= 1'b1;

      if (r_ack) begin
        request <= 1'b0;
        rbuf    <= rdata;
      end

      if (w_ack) begin
        request   <= 1'b0;
        address   <= address + ADDR_WIDTH'(gathered);
        remaining <= remaining - LEN_WIDTH'(gathered);
        gathered  <= '0;
        wdata     <= '0;
        wmask     <= '0;
      end

      if (push) begin
        tx_wdata  <= tx_byte;
        address   <= address + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end

      if (do_start) begin
        busy      <= 1'b1;
        write     <= direction;
        address   <= starting_address;
        remaining <= transfer_length;
        request   <= 1'b0;
        gathered  <= '0;
        wdata     <= '0;
        wmask     <= '0;
      end

      if (do_stop) begin
        busy    <= 1'b0;
        request <= 1'b0;
      end

      if (state_next == FINISH) busy <= 1'b0;
    end
  end

endmodule

// File: doc/memory_dma_wide.md
Name: memory_dma_wide

Overview:
Byte-stream DMA engine between a byte-wide device FIFO pair (rx/tx) and a memory port whose data word is MEM_BYTES bytes wide. It is the parametrised successor of the 16-bit DMA: configurable memory width and counter widths, arbitrary byte alignment, partial-word masking, and a completion pulse. It is started and stopped by the CPU register block and sits between the device FIFOs and the memory arbiter.

Parameters:
MEM_BYTES, 2, bytes per memory word; power of two, 2..8
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 32, transfer length / remaining counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin transfer (sampled only when idle)
stop  in  1  abort transfer (sampled only when busy)
direction  in  1  1 = FIFO->memory (write), 0 = memory->FIFO (read)
starting_address  in  ADDR_WIDTH  first byte address
transfer_length  in  LEN_WIDTH  byte count
busy  out  1  transfer in progress
done  out  1  one-cycle pulse on normal completion
remaining  out  LEN_WIDTH  bytes left
request  out  1  memory request, held until ack
ack  in  1  memory acknowledge (one cycle)
write  out  1  memory write enable
wmask  out  MEM_BYTES  byte-lane enables
address  out  ADDR_WIDTH  current byte address (memory ignores low log2(MEM_BYTES) bits)
rdata  in  8*MEM_BYTES  memory read data, valid with ack
wdata  out  8*MEM_BYTES  memory write data
rx_empty, rx_almost_empty  in  1  rx FIFO status
rx_read  out  1  rx pop strobe
rx_rdata  in  8  rx byte, valid the cycle after rx_read
tx_full, tx_almost_full  in  1  tx FIFO status
tx_write  out  1  tx push strobe
tx_wdata  out  8  tx byte

Behaviour:
- Reset (async, reset_n=0): every output 0, state IDLE. Reset mid-transfer aborts immediately; no done.
- Lane mapping: big-endian; byte at offset k = address mod MEM_BYTES occupies wdata/rdata bits [8*(MEM_BYTES-k)-1 : 8*(MEM_BYTES-k-1)], wmask bit MEM_BYTES-1-k.
- States: IDLE, FETCH, TRANSFER, FINISH.
- IDLE: start=1 -> busy=1, latch write=direction, address=starting_address, remaining=transfer_length, enter FETCH. start while busy is ignored. start and stop in the same idle cycle -> start wins.
- Any busy state: stop=1 -> busy=0, request=0, next cycle back to IDLE, no done; a late ack is ignored.
- remaining==0 in FETCH -> FINISH: busy=0, done=1 for exactly one cycle, then IDLE. A length-0 start gives done two cycles after start.
- Write, FETCH: pop one byte per cycle when !rx_empty && !(rx_read && rx_almost_empty). Captured byte goes to lane (address offset + bytes gathered). Unused lanes of wdata are 0; wmask has 1s only for gathered lanes. Word closes when the lane reaches MEM_BYTES-1 or gathered == remaining; then TRANSFER.
- Write, TRANSFER: request=1 from the first TRANSFER cycle; wdata/wmask stable until ack. On ack: request=0, address += n, remaining -= n (n = bytes in word), back to FETCH.
- Read, FETCH: request=1, write=0, until ack; latch rdata into the word buffer, request=0, then TRANSFER.
- Read, TRANSFER: push one byte per cycle when !tx_full && !(tx_write && tx_almost_full), starting at lane = address offset. After each push, address += 1 and remaining -= 1. Return to FETCH after lane MEM_BYTES-1 or when remaining hits 0.
- Throughput: at most one FIFO byte per cycle; one memory access per word. No byte is dropped or duplicated under any pattern of FIFO back-pressure.
- Arithmetic: address wraps modulo 2^ADDR_WIDTH. remaining never underflows because n <= remaining.

Test Plan:
- MEM_BYTES=4, write, addr 0x100, len 8, rx bytes 11..88 -> requests at 0x100 wdata 0x11223344 wmask 1111, then at 0x104 wdata 0x55667788 wmask 1111; done pulses once; busy=0.
- Write, addr 0x103, len 6, bytes 11..66 -> requests 0x103/0x00000011/0001, 0x104/0x22334455/1111, 0x108/0x66000000/1000.
- Read, addr 0x202, len 3, memory returns 0xAABBCCDD then 0x11223344 -> tx bytes CC, DD, 11; exactly two requests; remaining ends at 0.
- Read, len 16, tx_full high for 5 cycles mid-word and rx_empty toggling in a write run -> no strobe while full/empty; byte sequence matches exactly.
- Stop during a request with ack withheld -> next cycle request=0, busy=0, no done; a following start with len 2 completes normally.
- reset_n low mid-transfer -> all outputs 0 immediately; len 0 start -> done pulse, no memory or FIFO activity.
